// File: rtl/fx_bmem.sv
// Backup-memory responder: serves the CPU SRAM strobe from a 32 KiB block RAM with
// programmable wait states, plus a host byte port for save-file load/store.
module fx_bmem #(
   parameter int WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        RESn,
   input  logic        CE,
   input  logic        BCYSTn,
   input  logic        SRAM_CEn,
   input  logic        SRAM_WEn,
   input  logic [14:0] SRAM_A,
   input  logic [7:0]  SRAM_DI,
   output logic [7:0]  SRAM_DO,
   output logic        SRAM_READYn,
   input  logic [14:0] SD_A,
   input  logic        SD_RD,
   input  logic        SD_WR,
   input  logic [7:0]  SD_DI,
   output logic [7:0]  SD_DO,
   output logic        SD_ACK,
   output logic        DIRTY,
   input  logic        DIRTY_CLR
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CWAIT = 2'd1,
      S_CRESP = 2'd2,
      S_HOST  = 2'd3
   } state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_STATES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_pend;
   logic        r_we_n;
   logic [14:0] r_addr;
   logic [7:0]  r_di;
   logic        r_hph;
   logic        r_hwr;
   logic [14:0] r_haddr;
   logic [7:0]  r_hdi;
   logic        r_readyn;
   logic [7:0]  r_sram_do;
   logic [7:0]  r_sd_do;
   logic        r_sd_ack;
   logic        r_dirty;
   logic [7:0]  r_mem [0:32767];
   logic [7:0]  r_rdata;

   logic        w_start;
   logic        w_cpu_commit;
   logic        w_host_commit;
   logic        w_mem_we;
   logic [14:0] w_addr;
   logic [7:0]  w_wdata;

   assign w_start       = CE & ~BCYSTn & ~SRAM_CEn;
   assign w_cpu_commit  = (r_state == S_CRESP) & CE & ~r_we_n;
   assign w_host_commit = (r_state == S_HOST) & ~r_hph & r_hwr;
   // Gating with RESn lets a reset coinciding with the commit cycle win.
   assign w_mem_we      = RESn & (w_cpu_commit | w_host_commit);

   // In IDLE the address is steered to whichever access starts next, so the
   // synchronous read is already under way when CWAIT or HOST is entered.
   assign w_addr  = (r_state == S_HOST)  ? r_haddr :
                    (r_state != S_IDLE)  ? r_addr  :
                    r_pend               ? r_addr  :
                    w_start              ? SRAM_A  : SD_A;
   assign w_wdata = (r_state == S_HOST) ? r_hdi : r_di;

   assign SRAM_DO     = r_sram_do;
   assign SRAM_READYn = r_readyn;
   assign SD_DO       = r_sd_do;
   assign SD_ACK      = r_sd_ack;
   assign DIRTY       = r_dirty;

   always_ff @(posedge CLK) begin
      if (w_mem_we) begin
         r_mem[w_addr] <= w_wdata;
      end
      r_rdata <= r_mem[w_addr];
   end

   always_ff @(posedge CLK) begin
      if (!RESn) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_pend    <= 1'b0;
         r_we_n    <= 1'b1;
         r_addr    <= 15'd0;
         r_di      <= 8'd0;
         r_hph     <= 1'b0;
         r_hwr     <= 1'b0;
         r_haddr   <= 15'd0;
         r_hdi     <= 8'd0;
         r_readyn  <= 1'b1;
         r_sram_do <= 8'd0;
         r_sd_do   <= 8'd0;
         r_sd_ack  <= 1'b0;
         r_dirty   <= 1'b0;
      end else begin
         r_sd_ack <= 1'b0;
         if (w_start && !r_pend) begin
            r_pend <= 1'b1;
            r_addr <= SRAM_A;
            r_di   <= SRAM_DI;
            r_we_n <= SRAM_WEn;
         end
         case (r_state)
            S_IDLE: begin
               if (r_pend || w_start) begin
                  r_state <= S_CWAIT;
                  r_cnt   <= LP_CNT_INIT;
               end else if (SD_RD || SD_WR) begin
                  r_state <= S_HOST;
                  r_hph   <= 1'b0;
                  r_haddr <= SD_A;
                  r_hwr   <= SD_WR;
                  r_hdi   <= SD_DI;
               end
            end
            S_CWAIT: begin
               if (CE) begin
                  if (r_cnt == 4'd0) begin
                     r_state  <= S_CRESP;
                     r_readyn <= 1'b0;
                     if (r_we_n) begin
                        r_sram_do <= r_rdata;
                     end
                  end else begin
                     r_cnt <= r_cnt - 4'd1;
                  end
               end
            end
            S_CRESP: begin
               if (CE) begin
                  r_state  <= S_IDLE;
                  r_readyn <= 1'b1;
                  r_pend   <= 1'b0;
                  if (!r_we_n) begin
                     r_dirty <= 1'b1;
                  end
               end
            end
            S_HOST: begin
               if (!r_hph) begin
                  r_hph    <= 1'b1;
                  r_sd_ack <= 1'b1;
                  if (!r_hwr) begin
                     r_sd_do <= r_rdata;
                  end
               end else begin
                  r_hph   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         // A CPU write commit in the same cycle as a clear keeps DIRTY set.
         if (DIRTY_CLR && !w_cpu_commit) begin
            r_dirty <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fx_bmem.sv
// Directed bench for fx_bmem: one instance with WAIT_STATES=2 and one with
// WAIT_STATES=1 share all inputs; expected values are hand-computed.
module tb_fx_bmem;

   logic        CLK;
   logic        RESn;
   logic        CE;
   logic        BCYSTn;
   logic        SRAM_CEn;
   logic        SRAM_WEn;
   logic [14:0] SRAM_A;
   logic [7:0]  SRAM_DI;
   logic [14:0] SD_A;
   logic        SD_RD;
   logic        SD_WR;
   logic [7:0]  SD_DI;
   logic        DIRTY_CLR;

   logic [7:0]  SRAM_DO,     SRAM_DO_1;
   logic        SRAM_READYn, SRAM_READYn_1;
   logic [7:0]  SD_DO,       SD_DO_1;
   logic        SD_ACK,      SD_ACK_1;
   logic        DIRTY,       DIRTY_1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit ce_div4  = 1'b0;

   fx_bmem #(.WAIT_STATES(2)) u_dut (
      .CLK(CLK), .RESn(RESn), .CE(CE), .BCYSTn(BCYSTn), .SRAM_CEn(SRAM_CEn),
      .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO),
      .SRAM_READYn(SRAM_READYn), .SD_A(SD_A), .SD_RD(SD_RD), .SD_WR(SD_WR),
      .SD_DI(SD_DI), .SD_DO(SD_DO), .SD_ACK(SD_ACK), .DIRTY(DIRTY), .DIRTY_CLR(DIRTY_CLR)
   );

   fx_bmem #(.WAIT_STATES(1)) u_dut1 (
      .CLK(CLK), .RESn(RESn), .CE(CE), .BCYSTn(BCYSTn), .SRAM_CEn(SRAM_CEn),
      .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO_1),
      .SRAM_READYn(SRAM_READYn_1), .SD_A(SD_A), .SD_RD(SD_RD), .SD_WR(SD_WR),
      .SD_DI(SD_DI), .SD_DO(SD_DO_1), .SD_ACK(SD_ACK_1), .DIRTY(DIRTY_1), .DIRTY_CLR(DIRTY_CLR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Advance one CLK; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      CE = ce_div4 ? (cyc % 4 == 0) : 1'b1;
   endtask

   task automatic host_access(input bit rd, input bit wr, input logic [14:0] a,
                              input logic [7:0] d, output logic [7:0] rdata, output int lat);
      SD_A  = a;
      SD_DI = d;
      SD_RD = rd;
      SD_WR = wr;
      lat   = 0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         if (SD_ACK) begin
            lat = j;
            break;
         end
      end
      SD_RD = 1'b0;
      SD_WR = 1'b0;
      rdata = SD_DO;
      tick();
   endtask

   task automatic cpu_access(input logic we_n, input logic [14:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rdo);
      BCYSTn   = 1'b0;
      SRAM_CEn = 1'b0;
      SRAM_WEn = we_n;
      SRAM_A   = a;
      SRAM_DI  = d;
      lat      = 0;
      rdo      = 8'd0;
      for (int j = 1; j <= 20; j++) begin
         tick();
         BCYSTn   = 1'b1;
         SRAM_CEn = 1'b1;
         if (!SRAM_READYn) begin
            lat = j;
            rdo = SRAM_DO;
            break;
         end
      end
   endtask

   initial begin
      logic [7:0] rd;
      int         lat;
      int         rj, aj, f0, f1, n0, n1;

      RESn = 1'b0; CE = 1'b1; BCYSTn = 1'b1; SRAM_CEn = 1'b1; SRAM_WEn = 1'b1;
      SRAM_A = 15'd0; SRAM_DI = 8'd0; SD_A = 15'd0; SD_RD = 1'b0; SD_WR = 1'b0;
      SD_DI = 8'd0; DIRTY_CLR = 1'b0;
      repeat (3) tick();
      check("rst_readyn", 16'(SRAM_READYn), 16'd1);
      check("rst_sram_do", 16'(SRAM_DO), 16'd0);
      check("rst_sd_do", 16'(SD_DO), 16'd0);
      check("rst_sd_ack", 16'(SD_ACK), 16'd0);
      check("rst_dirty", 16'(DIRTY), 16'd0);
      check("rst_readyn_ws1", 16'(SRAM_READYn_1), 16'd1);
      RESn = 1'b1;
      tick();

      // Host load, then CPU read with two wait states.
      host_access(1'b0, 1'b1, 15'h0123, 8'h5A, rd, lat);
      check("host_wr_lat", 16'(lat), 16'd2);
      check("host_wr_no_dirty", 16'(DIRTY), 16'd0);
      cpu_access(1'b1, 15'h0123, 8'h00, lat, rd);
      check("cpu_rd_lat", 16'(lat), 16'd3);
      check("cpu_rd_data", 16'(rd), 16'h005A);
      tick();
      check("cpu_rd_ready_1cyc", 16'(SRAM_READYn), 16'd1);

      // CPU write to top address; DIRTY rises at the CRESP commit.
      cpu_access(1'b0, 15'h7FFF, 8'hC3, lat, rd);
      check("cpu_wr_lat", 16'(lat), 16'd3);
      check("cpu_wr_dirty_pre", 16'(DIRTY), 16'd0);
      tick();
      check("cpu_wr_dirty", 16'(DIRTY), 16'd1);
      check("cpu_wr_ready_1cyc", 16'(SRAM_READYn), 16'd1);
      host_access(1'b1, 1'b0, 15'h7FFF, 8'h00, rd, lat);
      check("host_rd_data", 16'(rd), 16'h00C3);
      check("host_rd_lat", 16'(lat), 16'd2);
      DIRTY_CLR = 1'b1;
      tick();
      DIRTY_CLR = 1'b0;
      check("dirty_clr", 16'(DIRTY), 16'd0);

      // RD and WR both high behaves as a write.
      host_access(1'b1, 1'b1, 15'h0010, 8'h3C, rd, lat);
      check("host_both_lat", 16'(lat), 16'd2);
      host_access(1'b1, 1'b0, 15'h0010, 8'h00, rd, lat);
      check("host_both_data", 16'(rd), 16'h003C);
      check("host_both_no_dirty", 16'(DIRTY), 16'd0);

      // Arbitration: host read and CPU read start in the same cycle.
      SD_A = 15'h7FFF; SD_RD = 1'b1;
      BCYSTn = 1'b0; SRAM_CEn = 1'b0; SRAM_WEn = 1'b1; SRAM_A = 15'h0123;
      rj = 0; aj = 0;
      for (int j = 1; j <= 20; j++) begin
         tick();
         BCYSTn = 1'b1; SRAM_CEn = 1'b1;
         if (!SRAM_READYn && rj == 0) rj = j;
         if (SD_ACK && aj == 0) begin
            aj = j;
            SD_RD = 1'b0;
         end
         if (rj != 0 && aj != 0) break;
      end
      SD_RD = 1'b0;
      check("arb_cpu_lat", 16'(rj), 16'd3);
      check("arb_host_lat", 16'(aj), 16'd6);
      check("arb_sd_do", 16'(SD_DO), 16'h00C3);
      check("arb_sram_do", 16'(SRAM_DO), 16'h005A);
      repeat (2) tick();

      // Clear coincides with the write commit: write wins.
      cpu_access(1'b0, 15'h0200, 8'h77, lat, rd);
      check("race_lat", 16'(lat), 16'd3);
      DIRTY_CLR = 1'b1;
      tick();
      DIRTY_CLR = 1'b0;
      check("race_dirty_kept", 16'(DIRTY), 16'd1);
      DIRTY_CLR = 1'b1;
      tick();
      DIRTY_CLR = 1'b0;
      check("race_dirty_clr", 16'(DIRTY), 16'd0);

      // Reset during CWAIT abandons the write.
      host_access(1'b0, 1'b1, 15'h0004, 8'h99, rd, lat);
      BCYSTn = 1'b0; SRAM_CEn = 1'b0; SRAM_WEn = 1'b0; SRAM_A = 15'h0004; SRAM_DI = 8'h11;
      tick();
      BCYSTn = 1'b1; SRAM_CEn = 1'b1; SRAM_WEn = 1'b1;
      RESn = 1'b0;
      tick();
      check("rstmid_readyn", 16'(SRAM_READYn), 16'd1);
      check("rstmid_readyn_ws1", 16'(SRAM_READYn_1), 16'd1);
      check("rstmid_dirty", 16'(DIRTY), 16'd0);
      check("rstmid_sram_do", 16'(SRAM_DO), 16'd0);
      RESn = 1'b1;
      repeat (2) tick();
      check("rstmid_dirty_ws1", 16'(DIRTY_1), 16'd0);
      host_access(1'b1, 1'b0, 15'h0004, 8'h00, rd, lat);
      check("rstmid_mem_kept", 16'(rd), 16'h0099);

      // CE every 4th CLK: READYn spans exactly one CE cycle.
      ce_div4 = 1'b1;
      for (int j = 0; j < 8; j++) begin
         tick();
         if (CE) break;
      end
      BCYSTn = 1'b0; SRAM_CEn = 1'b0; SRAM_WEn = 1'b1; SRAM_A = 15'h0123;
      f0 = 0; f1 = 0; n0 = 0; n1 = 0;
      for (int j = 1; j <= 24; j++) begin
         tick();
         BCYSTn = 1'b1; SRAM_CEn = 1'b1;
         if (!SRAM_READYn_1) begin
            if (f1 == 0) f1 = j;
            n1++;
         end
         if (!SRAM_READYn) begin
            if (f0 == 0) f0 = j;
            n0++;
         end
      end
      check("ce4_ws1_first", 16'(f1), 16'd5);
      check("ce4_ws1_len", 16'(n1), 16'd4);
      check("ce4_ws1_data", 16'(SRAM_DO_1), 16'h005A);
      check("ce4_ws2_first", 16'(f0), 16'd9);
      check("ce4_ws2_len", 16'(n0), 16'd4);
      ce_div4 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fx_bmem.md
# fx_bmem

Backup-memory responder for the 8-bit SRAM port of the machine assembly. It answers the V810-side SRAM strobe (`SRAM_CEn`/`SRAM_WEn`/`SRAM_READYn`) from an internal 32 KiB block RAM, inserting a programmable number of wait states. A second, host-side byte port lets the MiSTer save-file logic load and store the image. A dirty flag reports CPU writes since the last save.

## Interface
- `WAIT_STATES`, default 2: CE cycles between access start and `SRAM_READYn` assertion. Legal range 1–15.
- `CLK`  in  1: system clock.
- `RESn`  in  1: synchronous reset, active low.
- `CE`  in  1: CPU clock enable. The CPU side advances only on CE cycles.
- `BCYSTn`  in  1: CPU bus-cycle start strobe, active low, qualified by CE.
- `SRAM_CEn`  in  1: chip enable from the address decoder, active low.
- `SRAM_WEn`  in  1: 1 = read, 0 = write. This is CPU RW.
- `SRAM_A`  in  15: byte address.
- `SRAM_DI`  in  8: write data from the CPU.
- `SRAM_DO`  out  8: read data to the CPU.
- `SRAM_READYn`  out  1: access complete, active low.
- `SD_A`  in  15: host byte address.
- `SD_RD`  in  1: host read request, level.
- `SD_WR`  in  1: host write request, level.
- `SD_DI`  in  8: host write data.
- `SD_DO`  out  8: host read data.
- `SD_ACK`  out  1: one-CLK pulse when a host access completes.
- `DIRTY`  out  1: set by any CPU write.
- `DIRTY_CLR`  in  1: one-CLK clear pulse for `DIRTY`.

## Operation
- **Storage:** 32768×8 single-port BRAM with synchronous read (1 CLK). Contents are not cleared by reset.
- **CPU start:** a CE cycle with `~BCYSTn & ~SRAM_CEn` sets `cpu_pend` and latches A, DI and WEn. If the FSM is not in IDLE, `cpu_pend` holds the request.
- **FSM states:** IDLE, CWAIT, CRESP, HOST.
  - **IDLE:**
    - If `cpu_pend`: go to CWAIT with `cnt = WAIT_STATES-1`.
    - Else if `SD_RD|SD_WR`: go to HOST.
    - CPU has priority over host.
  - **CWAIT:**
    - On each CE cycle, if `cnt == 0` go to CRESP; otherwise decrement `cnt`.
    - A read issues the BRAM read on entry to CWAIT.
  - **CRESP:**
    - Lasts exactly one CE cycle, with `SRAM_READYn = 0`.
    - Read: `SRAM_DO` is valid here and holds until the next CPU read completes.
    - Write: the BRAM write of the latched data and the set of `DIRTY` happen on the CE cycle of CRESP.
    - Clears `cpu_pend`, then returns to IDLE.
  - **HOST:**
    - Two CLK cycles.
    - Write: committed on the first cycle.
    - Read: data is captured to `SD_DO` on the second cycle.
    - `SD_ACK` pulses on the second cycle, then the FSM returns to IDLE.
    - The host must deassert its request after ACK. A request still high in IDLE starts a new access.
    - `SD_RD` and `SD_WR` both high is treated as a write.
- **DIRTY:** a clear and a CPU write in the same CLK leave `DIRTY = 1` (write wins). Host writes never set `DIRTY`.
- **Address width:** `SRAM_A` and `SD_A` are used directly as the 15-bit index, with no wrap logic.

## Timing
- **Reset values:** `SRAM_READYn = 1`, `SRAM_DO = 0`, `SD_DO = 0`, `SD_ACK = 0`, `DIRTY = 0`, state = IDLE, `cpu_pend = 0`.
- **CPU latency:** the start CE cycle is t. `READYn` is low on CE cycle `t + WAIT_STATES + 1`, provided no host access is in progress at t.
- **Collision:** a CPU start during HOST is delayed by at most 2 CLK. If CE is present every CLK, this adds at most 2 CE cycles.
- **Host latency:** request seen in IDLE at CLK n gives ACK at CLK n+2, provided no CPU access is pending. Host accesses stall while a CPU access is in progress.
- **Ignored strobes:** a CPU start while `cpu_pend` is already set is ignored. The V810 waits for `READYn`, so this cannot occur legally. `SRAM_CEn` rising mid-access does not abort the access.
- **Reset mid-access:** the access is abandoned and no write is committed. If reset coincides with the commit cycle, reset wins.

## Test plan
- **CPU read:** host-write 0x5A to 0x0123; CPU read 0x0123 with CE every CLK and `WAIT_STATES = 2` → `READYn` low on CE cycle t+3 only, `SRAM_DO = 0x5A`.
- **CPU write:** CPU write 0xC3 to 0x7FFF → `DIRTY` rises on the CRESP cycle; host read 0x7FFF returns 0xC3 with ACK 2 CLK after the request.
- **Arbitration:** `SD_RD` and CPU start asserted in the same CLK → CPU `READYn` at t+3; host ACK follows the CPU completion by 2 CLK.
- **Dirty race:** `DIRTY_CLR` pulsed on the same CLK as a CPU write commit → `DIRTY` stays 1; a later lone `DIRTY_CLR` → 0.
- **Reset mid-access:** CPU write of 0x11 to 0x0004, `RESn` low during CWAIT → `READYn = 1`, `DIRTY = 0`, and address 0x0004 keeps its prior value.
- **CE gating:** CE every 4th CLK with `WAIT_STATES = 1` → `READYn` low for exactly 4 CLK spanning a single CE cycle, at CE cycle t+2.
